// File: rtl/cmp_mag_serial_pkg.sv
// ----------------------------------------------------------------------------
// cmp_mag_serial_pkg
//   Shared definitions for the serial magnitude comparator:
//     - FSM state encodings (S_IDLE, S_RUN)
//     - result flag bundle {eq, gt, lt}
//     - idx_width(): index counter width, never less than one bit
//     - make_flags(): one-hot result from "any chunk differed" and "A won"
// ----------------------------------------------------------------------------
package cmp_mag_serial_pkg;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  typedef struct packed {
    logic eq;
    logic gt;
    logic lt;
  } cmp_flags_t;

  localparam cmp_flags_t FLAGS_CLEAR = '{eq: 1'b0, gt: 1'b0, lt: 1'b0};

  // Ceiling log2 with a floor of one bit, so a single-chunk comparator still
  // has a legal (constant zero) index register.
  function automatic int idx_width(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) begin
      w = w + 1;
    end
    return (w < 1) ? 1 : w;
  endfunction

  // Exactly one flag is set for any completed compare.
  function automatic cmp_flags_t make_flags(input logic any_diff, input logic a_greater);
    cmp_flags_t f;
    f.eq = ~any_diff;
    f.gt = any_diff & a_greater;
    f.lt = any_diff & ~a_greater;
    return f;
  endfunction

endpackage

// File: rtl/cmp_mag_serial_chunk.sv
// ----------------------------------------------------------------------------
// cmp_mag_serial_chunk
//   Combinational compare of one CHUNK-bit slice.
//   Equality is an AND chain of 1-bit equality cells; greater-than is an
//   MSB-first priority chain: bit i decides only when every bit above it
//   is equal.
// Ports:
//   x   in  CHUNK  slice of operand A
//   y   in  CHUNK  slice of operand B
//   eq  out 1      x == y
//   gt  out 1      x > y (unsigned)
// ----------------------------------------------------------------------------
module cmp_mag_serial_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  output logic             eq,
  output logic             gt
);

  logic [CHUNK-1:0] bit_eq;
  // above_eq[i+1] = all bits strictly above bit i are equal
  logic [CHUNK:0]   above_eq;
  logic [CHUNK-1:0] bit_wins;

  always_comb begin
    bit_eq   = ~(x ^ y);
    above_eq = '0;
    above_eq[CHUNK] = 1'b1;
    for (int i = CHUNK - 1; i >= 0; i--) begin
      above_eq[i] = above_eq[i+1] & bit_eq[i];
    end
    bit_wins = x & ~y & above_eq[CHUNK:1];
  end

  assign eq = above_eq[0];
  assign gt = |bit_wins;

endmodule

// File: rtl/cmp_mag_serial.sv
// ----------------------------------------------------------------------------
// cmp_mag_serial
//   Multi-cycle WIDTH-bit magnitude comparator, CHUNK bits per clock, MSB
//   chunk first. Optional early exit on the first differing chunk and
//   optional two's-complement compare (MSB of both operands inverted on
//   capture, turning the signed compare into an unsigned one).
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   S_IDLE | waiting for start; done pulse (if any) is visible here
//   S_RUN  | comparing chunk idx each edge; busy=1
//
// Ports:
//   clk    in   1      rising-edge clock
//   reset  in   1      asynchronous active-high reset
//   start  in   1      request, accepted only while busy=0
//   a, b   in   WIDTH  operands, sampled on the accepting edge
//   busy   out  1      compare in progress
//   done   out  1      one-cycle pulse when eq/gt/lt update
//   eq     out  1      A == B of the last completed compare
//   gt     out  1      A >  B of the last completed compare
//   lt     out  1      A <  B of the last completed compare
// ----------------------------------------------------------------------------
module cmp_mag_serial
  import cmp_mag_serial_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int CHUNK      = 4,
  parameter int EARLY_EXIT = 1,
  parameter int SIGNED     = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic             gt,
  output logic             lt
);

  localparam int NCHUNK = (CHUNK > 0) ? (WIDTH / CHUNK) : 1;
  localparam int IDXW   = idx_width(NCHUNK);

  localparam logic [IDXW-1:0]  IDX_LAST = IDXW'(NCHUNK - 1);
  localparam logic [WIDTH-1:0] MSB_FLIP = (SIGNED != 0) ? (WIDTH'(1) << (WIDTH - 1)) : '0;

  if (CHUNK < 1 || CHUNK > WIDTH) begin : g_bad_chunk
    $error("cmp_mag_serial: CHUNK must be in 1..WIDTH");
  end else if ((WIDTH % CHUNK) != 0) begin : g_bad_width
    $error("cmp_mag_serial: WIDTH must be a multiple of CHUNK");
  end

  logic [0:0]       state_q;
  logic [IDXW-1:0]  idx_q;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic             diff_q;
  logic             gt_seen_q;
  logic             busy_q;
  logic             done_q;
  cmp_flags_t       flags_q;

  logic             c_eq;
  logic             c_gt;
  logic             first_diff;
  logic             last_chunk;
  logic             finish;
  logic             any_diff;
  logic             final_gt;

  // Operands are shifted left each RUN edge so the chunk under test is
  // always the top CHUNK bits; no variable part-select is needed.
  cmp_mag_serial_chunk #(
    .CHUNK (CHUNK)
  ) u_chunk (
    .x  (a_sh_q[WIDTH-1 -: CHUNK]),
    .y  (b_sh_q[WIDTH-1 -: CHUNK]),
    .eq (c_eq),
    .gt (c_gt)
  );

  always_comb begin
    first_diff = ~diff_q & ~c_eq;
    last_chunk = (idx_q == IDX_LAST);
    finish     = last_chunk | ((EARLY_EXIT != 0) & first_diff);
    any_diff   = diff_q | first_diff;
    // The first differing chunk decides the order; later chunks are ignored.
    final_gt   = first_diff ? c_gt : gt_seen_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      a_sh_q    <= '0;
      b_sh_q    <= '0;
      diff_q    <= 1'b0;
      gt_seen_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      flags_q   <= FLAGS_CLEAR;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            a_sh_q    <= a ^ MSB_FLIP;
            b_sh_q    <= b ^ MSB_FLIP;
            idx_q     <= '0;
            diff_q    <= 1'b0;
            gt_seen_q <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= S_RUN;
          end
        end

        S_RUN: begin
          done_q <= 1'b0;
          if (first_diff) begin
            diff_q    <= 1'b1;
            gt_seen_q <= c_gt;
          end
          if (finish) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            flags_q <= make_flags(any_diff, final_gt);
            state_q <= S_IDLE;
          end else begin
            idx_q  <= idx_q + 1'b1;
            a_sh_q <= a_sh_q << CHUNK;
            b_sh_q <= b_sh_q << CHUNK;
          end
        end

        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign eq   = flags_q.eq;
  assign gt   = flags_q.gt;
  assign lt   = flags_q.lt;

endmodule

// File: tb/tb_cmp_mag_serial.sv
// ----------------------------------------------------------------------------
// tb_cmp_mag_serial
//   Four comparators share clk/reset/start/a/b:
//     inst 0: 16/4 early exit, unsigned
//     inst 1: 16/4 no early exit, unsigned
//     inst 2: 16/4 early exit, signed
//     inst 3:  8/8 early exit, unsigned (low byte of a/b)
// ----------------------------------------------------------------------------
module tb_cmp_mag_serial;

  localparam logic [2:0] F_EQ = 3'b100;
  localparam logic [2:0] F_GT = 3'b010;
  localparam logic [2:0] F_LT = 3'b001;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] a_in;
  logic [15:0] b_in;

  logic [3:0] busy_w;
  logic [3:0] done_w;
  logic [3:0] eq_w;
  logic [3:0] gt_w;
  logic [3:0] lt_w;

  int n_tests;
  int n_fail;

  int         dedge  [4];
  int         dcount [4];
  logic [2:0] dflag  [4];

  cmp_mag_serial #(.WIDTH(16), .CHUNK(4), .EARLY_EXIT(1), .SIGNED(0)) u_ee (
    .clk(clk), .reset(reset), .start(start), .a(a_in), .b(b_in),
    .busy(busy_w[0]), .done(done_w[0]), .eq(eq_w[0]), .gt(gt_w[0]), .lt(lt_w[0]));

  cmp_mag_serial #(.WIDTH(16), .CHUNK(4), .EARLY_EXIT(0), .SIGNED(0)) u_noee (
    .clk(clk), .reset(reset), .start(start), .a(a_in), .b(b_in),
    .busy(busy_w[1]), .done(done_w[1]), .eq(eq_w[1]), .gt(gt_w[1]), .lt(lt_w[1]));

  cmp_mag_serial #(.WIDTH(16), .CHUNK(4), .EARLY_EXIT(1), .SIGNED(1)) u_sgn (
    .clk(clk), .reset(reset), .start(start), .a(a_in), .b(b_in),
    .busy(busy_w[2]), .done(done_w[2]), .eq(eq_w[2]), .gt(gt_w[2]), .lt(lt_w[2]));

  cmp_mag_serial #(.WIDTH(8), .CHUNK(8), .EARLY_EXIT(1), .SIGNED(0)) u_w8 (
    .clk(clk), .reset(reset), .start(start), .a(a_in[7:0]), .b(b_in[7:0]),
    .busy(busy_w[3]), .done(done_w[3]), .eq(eq_w[3]), .gt(gt_w[3]), .lt(lt_w[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present operands with start and let edge 0 accept them; returns #1 after edge 0.
  task automatic issue(input logic [15:0] av, input logic [15:0] bv);
    a_in  = av;
    b_in  = bv;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Watch 8 edges after acceptance, recording first done edge, flags and pulse count.
  task automatic run_compare(input logic [15:0] av, input logic [15:0] bv);
    for (int i = 0; i < 4; i++) begin
      dedge[i]  = -1;
      dcount[i] = 0;
      dflag[i]  = 3'b000;
    end
    issue(av, bv);
    for (int e = 1; e <= 8; e++) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
        if (done_w[i]) begin
          dcount[i]++;
          if (dedge[i] < 0) begin
            dedge[i] = e;
            dflag[i] = {eq_w[i], gt_w[i], lt_w[i]};
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if ({busy_w[i], done_w[i], eq_w[i], gt_w[i], lt_w[i]} !== 5'b00000) begin
        n_fail++;
        $display("FAIL reset_state inst%0d: got %b, want 00000", i,
                 {busy_w[i], done_w[i], eq_w[i], gt_w[i], lt_w[i]});
      end
    end
  endtask

  // Equal operands: busy after edges 0..3, done after edge 4, flags hold after.
  task automatic test_equal_timing();
    logic [1:0] exp_bd;
    issue(16'h1234, 16'h1234);
    n_tests++;
    if ({busy_w[0], done_w[0]} !== 2'b10) begin
      n_fail++;
      $display("FAIL equal_edge0: busy/done got %b, want 10", {busy_w[0], done_w[0]});
    end
    for (int e = 1; e <= 5; e++) begin
      @(posedge clk);
      #1;
      exp_bd = (e < 4) ? 2'b10 : ((e == 4) ? 2'b01 : 2'b00);
      n_tests++;
      if ({busy_w[0], done_w[0]} !== exp_bd) begin
        n_fail++;
        $display("FAIL equal_edge%0d: busy/done got %b, want %b", e, {busy_w[0], done_w[0]}, exp_bd);
      end
      if (e >= 4) begin
        n_tests++;
        if ({eq_w[0], gt_w[0], lt_w[0]} !== F_EQ) begin
          n_fail++;
          $display("FAIL equal_flags_edge%0d: got %b, want %b", e, {eq_w[0], gt_w[0], lt_w[0]}, F_EQ);
        end
      end
    end
    // w8 (34 vs 34) and the others finish well inside this window
    for (int e = 6; e <= 8; e++) @(posedge clk);
    #1;
  endtask

  task automatic test_directed();
    logic [15:0] va [5];
    logic [15:0] vb [5];
    int          ve [5][4];
    logic [2:0]  vf [5][4];
    va = '{16'h8000, 16'h1235, 16'h2000, 16'h1200, 16'hFFFF};
    vb = '{16'h7FFF, 16'h1234, 16'h1FFF, 16'h1300, 16'h0001};
    ve = '{'{1, 4, 1, 1}, '{4, 4, 4, 1}, '{1, 4, 1, 1}, '{2, 4, 2, 1}, '{1, 4, 1, 1}};
    vf = '{'{F_GT, F_GT, F_LT, F_LT},
           '{F_GT, F_GT, F_GT, F_GT},
           '{F_GT, F_GT, F_GT, F_LT},
           '{F_LT, F_LT, F_LT, F_EQ},
           '{F_GT, F_GT, F_LT, F_GT}};
    for (int v = 0; v < 5; v++) begin
      run_compare(va[v], vb[v]);
      for (int i = 0; i < 4; i++) begin
        n_tests++;
        if (dedge[i] !== ve[v][i] || dflag[i] !== vf[v][i] || dcount[i] !== 1) begin
          n_fail++;
          $display("FAIL directed v%0d inst%0d: edge %0d flags %b pulses %0d, want edge %0d flags %b pulses 1",
                   v, i, dedge[i], dflag[i], dcount[i], ve[v][i], vf[v][i]);
        end
      end
    end
  endtask

  // start while busy is ignored; start held in the done cycle is accepted.
  task automatic test_back_to_back();
    int          e2;
    logic [2:0]  f2;
    issue(16'h1235, 16'h1234);
    a_in = 16'h0001; b_in = 16'hF000; start = 1'b1;
    @(posedge clk); #1;             // edge 1
    start = 1'b0;
    @(posedge clk); #1;             // edge 2
    start = 1'b1;
    @(posedge clk); #1;             // edge 3
    start = 1'b0;
    @(posedge clk); #1;             // edge 4
    for (int i = 0; i < 2; i++) begin
      n_tests++;
      if ({busy_w[i], done_w[i], eq_w[i], gt_w[i], lt_w[i]} !== {2'b01, F_GT}) begin
        n_fail++;
        $display("FAIL ignore_busy_start inst%0d: got %b, want 01010", i,
                 {busy_w[i], done_w[i], eq_w[i], gt_w[i], lt_w[i]});
      end
    end
    a_in = 16'h0001; b_in = 16'h0002; start = 1'b1;
    @(posedge clk); #1;             // edge 5 accepts the second compare
    start = 1'b0;
    n_tests++;
    if ({busy_w[0], done_w[0], eq_w[0], gt_w[0], lt_w[0]} !== {2'b10, F_GT}) begin
      n_fail++;
      $display("FAIL b2b_accept: got %b, want 10010", {busy_w[0], done_w[0], eq_w[0], gt_w[0], lt_w[0]});
    end
    e2 = -1;
    f2 = 3'b000;
    for (int e = 1; e <= 8; e++) begin
      @(posedge clk); #1;
      if (done_w[0] && e2 < 0) begin
        e2 = e;
        f2 = {eq_w[0], gt_w[0], lt_w[0]};
      end
    end
    n_tests++;
    if (e2 !== 4 || f2 !== F_LT) begin
      n_fail++;
      $display("FAIL b2b_second: edge %0d flags %b, want edge 4 flags %b", e2, f2, F_LT);
    end
  endtask

  task automatic test_reset_mid_run();
    logic seen_done;
    issue(16'h1235, 16'h1234);
    @(posedge clk); #1;
    @(posedge clk); #1;             // after edge 2
    reset = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if ({busy_w[i], done_w[i], eq_w[i], gt_w[i], lt_w[i]} !== 5'b00000) begin
        n_fail++;
        $display("FAIL reset_async inst%0d: got %b, want 00000", i,
                 {busy_w[i], done_w[i], eq_w[i], gt_w[i], lt_w[i]});
      end
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    seen_done = 1'b0;
    for (int e = 0; e < 4; e++) begin
      @(posedge clk); #1;
      if (done_w[0]) seen_done = 1'b1;
    end
    n_tests++;
    if (seen_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_no_done: done pulse seen %b, want 0", seen_done);
    end
    run_compare(16'h0001, 16'h0002);
    n_tests++;
    if (dedge[0] !== 4 || dflag[0] !== F_LT) begin
      n_fail++;
      $display("FAIL reset_fresh: edge %0d flags %b, want edge 4 flags %b", dedge[0], dflag[0], F_LT);
    end
  endtask

  // Random operands against a plain compare model for all four instances.
  task automatic test_random_sweep();
    logic [15:0] av, bv;
    int          k;
    logic [2:0]  fu, fs, f8;
    int          we [4];
    logic [2:0]  wf [4];
    for (int n = 0; n < 24; n++) begin
      av = 16'($urandom);
      bv = (n % 4 == 0) ? av : 16'($urandom);
      if (n % 4 == 1) bv = {av[15:4], 4'($urandom)};
      k = 3;
      for (int c = 3; c >= 0; c--) begin
        if (((av >> (12 - 4 * c)) & 16'h000F) != ((bv >> (12 - 4 * c)) & 16'h000F)) k = c;
      end
      fu = (av == bv) ? F_EQ : ((av > bv) ? F_GT : F_LT);
      fs = (av == bv) ? F_EQ : (($signed(av) > $signed(bv)) ? F_GT : F_LT);
      f8 = (av[7:0] == bv[7:0]) ? F_EQ : ((av[7:0] > bv[7:0]) ? F_GT : F_LT);
      we = '{k + 1, 4, k + 1, 1};
      wf = '{fu, fu, fs, f8};
      run_compare(av, bv);
      for (int i = 0; i < 4; i++) begin
        n_tests++;
        if (dedge[i] !== we[i] || dflag[i] !== wf[i] || dcount[i] !== 1) begin
          n_fail++;
          $display("FAIL sweep a=%h b=%h inst%0d: edge %0d flags %b pulses %0d, want edge %0d flags %b pulses 1",
                   av, bv, i, dedge[i], dflag[i], dcount[i], we[i], wf[i]);
        end
      end
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b1;
    start   = 1'b0;
    a_in    = '0;
    b_in    = '0;
    @(posedge clk); #1;
    test_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    test_equal_timing();
    test_directed();
    test_back_to_back();
    test_reset_mid_run();
    test_random_sweep();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
